// File: rtl/bnn_infer_ctrl_if.sv
// Signal bundle between bnn_infer_ctrl (master) and the image buffer, BNN core and
// result consumer (slave).
interface bnn_infer_ctrl_if #(
    parameter int IMG_BITS = 904,
    parameter int RES_BITS = 4
);
    logic [IMG_BITS-1:0] img_in;
    logic                img_buffer_full;
    logic                bnn_start;
    logic                img_consumed;
    logic [IMG_BITS-1:0] core_img;
    logic                core_start;
    logic                core_done;
    logic [RES_BITS-1:0] core_result;
    logic [RES_BITS-1:0] result_out;
    logic                result_ready;
    logic                result_ack;
    logic                err_timeout;
    logic                busy;

    modport master (
        input  img_in, img_buffer_full, bnn_start, core_done, core_result, result_ack,
        output img_consumed, core_img, core_start, result_out, result_ready, err_timeout, busy
    );

    modport slave (
        output img_in, img_buffer_full, bnn_start, core_done, core_result, result_ack,
        input  img_consumed, core_img, core_start, result_out, result_ready, err_timeout, busy
    );
endinterface

// File: rtl/bnn_infer_ctrl.sv
// BNN inference controller: captures an image, pulses the core, supervises it with a
// timeout and holds the class result for the consumer. BNN_CTRL_PERF_EN adds last_latency.
module bnn_infer_ctrl #(
    parameter int IMG_BITS       = 904,
    parameter int RES_BITS       = 4,
    parameter int DONE_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
`ifdef BNN_CTRL_PERF_EN
    output logic [15:0]      last_latency,
`endif
    bnn_infer_ctrl_if.master bus
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > DONE_CYCLES) ? TIMEOUT_CYCLES : DONE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DONE_LAST    = CNT_W'(DONE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             ready_d, err_d;
    logic             capture, latch_result;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            cnt              <= '0;
            // NOTE: the wide image register is reset as well so core_img reads 0 after reset.
            bus.core_img     <= '0;
            bus.result_out   <= '0;
            bus.result_ready <= 1'b0;
            bus.err_timeout  <= 1'b0;
        end else begin
            state            <= state_d;
            cnt              <= cnt_d;
            bus.result_ready <= ready_d;
            bus.err_timeout  <= err_d;
            if (capture)      bus.core_img   <= bus.img_in;
            if (latch_result) bus.result_out <= bus.core_result;
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d          = state;
        cnt_d            = cnt;
        ready_d          = bus.result_ready;
        err_d            = bus.err_timeout;
        capture          = 1'b0;
        latch_result     = 1'b0;
        bus.img_consumed = 1'b0;
        bus.core_start   = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.img_buffer_full && bus.bnn_start) begin
                    capture          = 1'b1;
                    bus.img_consumed = 1'b1;
                    state_d          = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                bus.core_start = 1'b1;
                cnt_d          = '0;
                state_d        = S_WAIT;
            end
            S_WAIT: begin
                // Done is tested first so a result on the last allowed cycle still wins.
                if (bus.core_done) begin
                    latch_result = 1'b1;
                    ready_d      = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_DONE;
                end else if (cnt == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.result_ack || cnt == DONE_LAST) begin
                    ready_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_ERR: begin
                if (bus.result_ack) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reset dominates: no handshake pulse may escape during a reset cycle.
        if (rst) begin
            bus.img_consumed = 1'b0;
            bus.core_start   = 1'b0;
        end
    end

    assign bus.busy = (state != S_IDLE);

`ifdef BNN_CTRL_PERF_EN
    // lat_cnt equals the number of cycles since core_start while in WAIT.
    logic [15:0] lat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt      <= '0;
            last_latency <= '0;
        end else begin
            if (state == S_LAUNCH) begin
                lat_cnt <= 16'd1;
            end else if (state == S_WAIT && lat_cnt != 16'hFFFF) begin
                lat_cnt <= lat_cnt + 16'd1;
            end
            if (latch_result) last_latency <= lat_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_bnn_infer_ctrl.sv
// Self-checking bench for bnn_infer_ctrl: randomized transactions against a
// transaction-level expectation model.
module tb_bnn_infer_ctrl;
    localparam int IMG_BITS       = 904;
    localparam int RES_BITS       = 4;
    localparam int DONE_CYCLES    = 16;
    localparam int TIMEOUT_CYCLES = 12;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model state: what result_out / last_latency must currently read.
    logic [RES_BITS-1:0] exp_result;
    logic [15:0]         exp_latency;

    bnn_infer_ctrl_if #(.IMG_BITS(IMG_BITS), .RES_BITS(RES_BITS)) bus ();

`ifdef BNN_CTRL_PERF_EN
    logic [15:0] last_latency;
`endif

    bnn_infer_ctrl #(
        .IMG_BITS(IMG_BITS),
        .RES_BITS(RES_BITS),
        .DONE_CYCLES(DONE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef BNN_CTRL_PERF_EN
        .last_latency(last_latency),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [IMG_BITS-1:0] rand_img();
        logic [IMG_BITS-1:0] r;
        for (int i = 0; i < IMG_BITS; i++) r[i] = 1'($urandom);
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.img_buffer_full = 1'b0;
        bus.bnn_start       = 1'b0;
        bus.core_done       = 1'b0;
        bus.result_ack      = 1'b0;
    endtask

    task automatic check_perf(input string name);
`ifdef BNN_CTRL_PERF_EN
        n_checks++; if (last_latency !== exp_latency) $display("FAIL %s last_latency: got %0d want %0d", name, last_latency, exp_latency); else n_pass++;
`endif
    endtask

    task automatic check_idle(input string name);
        quiet_inputs();
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL %s busy: got %b want 0", name, bus.busy); else n_pass++;
        n_checks++; if (bus.result_ready !== 1'b0) $display("FAIL %s result_ready: got %b want 0", name, bus.result_ready); else n_pass++;
        n_checks++; if (bus.err_timeout !== 1'b0) $display("FAIL %s err_timeout: got %b want 0", name, bus.err_timeout); else n_pass++;
        n_checks++; if (bus.result_out !== exp_result) $display("FAIL %s result_out: got %0d want %0d", name, bus.result_out, exp_result); else n_pass++;
        next_cycle();
    endtask

    // Capture cycle in IDLE followed by the LAUNCH cycle; returns at the first WAIT cycle.
    task automatic launch(input logic [IMG_BITS-1:0] img);
        bus.img_in = img; bus.img_buffer_full = 1'b1; bus.bnn_start = 1'b1;
        bus.core_done = 1'b0; bus.result_ack = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.img_consumed !== 1'b1) $display("FAIL capture img_consumed: got %b want 1", bus.img_consumed); else n_pass++;
        n_checks++; if (bus.core_start !== 1'b0) $display("FAIL capture core_start: got %b want 0", bus.core_start); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL capture busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.result_ready !== 1'b0) $display("FAIL capture result_ready: got %b want 0", bus.result_ready); else n_pass++;
        n_checks++; if (bus.result_out !== exp_result) $display("FAIL capture result_out: got %0d want %0d", bus.result_out, exp_result); else n_pass++;
        next_cycle();
        bus.img_in = rand_img(); bus.img_buffer_full = 1'($urandom); bus.bnn_start = 1'($urandom);
        @(negedge clk);
        n_checks++; if (bus.core_start !== 1'b1) $display("FAIL launch core_start: got %b want 1", bus.core_start); else n_pass++;
        n_checks++; if (bus.img_consumed !== 1'b0) $display("FAIL launch img_consumed: got %b want 0", bus.img_consumed); else n_pass++;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL launch busy: got %b want 1", bus.busy); else n_pass++;
        n_checks++; if (bus.core_img !== img) $display("FAIL launch core_img: got %h want %h", bus.core_img, img); else n_pass++;
        next_cycle();
    endtask

    // One full successful inference: core answers lat cycles after core_start,
    // consumer acks on DONE cycle ack_at (0 or > DONE_CYCLES means never).
    task automatic run_txn(input logic [IMG_BITS-1:0] img, input logic [RES_BITS-1:0] res,
                           input int lat, input int ack_at);
        int exp_ready;
        launch(img);
        for (int w = 1; w <= lat; w++) begin
            bus.img_buffer_full = 1'($urandom); bus.bnn_start = 1'($urandom);
            bus.core_done   = (w == lat);
            bus.core_result = (w == lat) ? res : RES_BITS'($urandom);
            @(negedge clk);
            n_checks++; if (bus.core_start !== 1'b0) $display("FAIL wait core_start: got %b want 0", bus.core_start); else n_pass++;
            n_checks++; if (bus.img_consumed !== 1'b0) $display("FAIL wait img_consumed: got %b want 0", bus.img_consumed); else n_pass++;
            n_checks++; if (bus.result_ready !== 1'b0) $display("FAIL wait result_ready: got %b want 0", bus.result_ready); else n_pass++;
            n_checks++; if (bus.core_img !== img) $display("FAIL wait core_img: got %h want %h", bus.core_img, img); else n_pass++;
            next_cycle();
        end
        exp_result  = res;
        exp_latency = 16'(lat);
        exp_ready   = (ack_at >= 1 && ack_at <= DONE_CYCLES) ? ack_at : DONE_CYCLES;
        for (int d = 1; d <= exp_ready; d++) begin
            bus.result_ack      = (d == ack_at);
            bus.img_buffer_full = 1'($urandom); bus.bnn_start = 1'($urandom);
            bus.core_done       = 1'($urandom);
            bus.core_result     = RES_BITS'($urandom);
            @(negedge clk);
            n_checks++; if (bus.result_ready !== 1'b1) $display("FAIL done result_ready cycle %0d: got %b want 1", d, bus.result_ready); else n_pass++;
            n_checks++; if (bus.result_out !== res) $display("FAIL done result_out: got %0d want %0d", bus.result_out, res); else n_pass++;
            n_checks++; if (bus.busy !== 1'b1) $display("FAIL done busy: got %b want 1", bus.busy); else n_pass++;
            n_checks++; if (bus.img_consumed !== 1'b0) $display("FAIL done img_consumed: got %b want 0", bus.img_consumed); else n_pass++;
            if (d == 1) check_perf("done");
            next_cycle();
        end
        quiet_inputs();
    endtask

    task automatic test_reset();
        quiet_inputs();
        bus.img_in = rand_img(); bus.core_result = '0;
        rst = 1'b1;
        next_cycle();
        bus.img_buffer_full = 1'b1; bus.bnn_start = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.img_consumed !== 1'b0) $display("FAIL reset img_consumed: got %b want 0", bus.img_consumed); else n_pass++;
        n_checks++; if (bus.core_start !== 1'b0) $display("FAIL reset core_start: got %b want 0", bus.core_start); else n_pass++;
        next_cycle();
        rst = 1'b0;
        exp_result = '0; exp_latency = '0;
        quiet_inputs();
        @(negedge clk);
        n_checks++; if (bus.core_img !== '0) $display("FAIL reset core_img: got %h want 0", bus.core_img); else n_pass++;
        check_perf("reset");
        check_idle("reset");
    endtask

    task automatic test_nominal();
        logic [IMG_BITS-1:0] pat_a;
        for (int i = 0; i < IMG_BITS; i++) pat_a[i] = (i % 3 == 0);
        run_txn(pat_a, 4'd7, 10, 3);
        check_idle("nominal_end");
    endtask

    task automatic test_hold_expiry();
        run_txn(rand_img(), RES_BITS'($urandom), 4, 0);
        check_idle("hold_expiry_end");
    endtask

    task automatic test_done_on_last();
        run_txn(rand_img(), RES_BITS'($urandom), TIMEOUT_CYCLES, 5);
        check_idle("done_on_last_end");
    endtask

    task automatic test_back_to_back();
        run_txn(rand_img(), RES_BITS'($urandom), 3, 2);
        run_txn(rand_img(), RES_BITS'($urandom), 1, 1);
        run_txn(rand_img(), RES_BITS'($urandom), 2, 1);
        check_idle("back_to_back_end");
    endtask

    task automatic test_timeout();
        launch(rand_img());
        for (int w = 1; w <= TIMEOUT_CYCLES; w++) begin
            bus.core_done = 1'b0; bus.img_buffer_full = 1'($urandom);
            @(negedge clk);
            n_checks++; if (bus.err_timeout !== 1'b0) $display("FAIL timeout early err: got %b want 0 at wait %0d", bus.err_timeout, w); else n_pass++;
            n_checks++; if (bus.busy !== 1'b1) $display("FAIL timeout wait busy: got %b want 1", bus.busy); else n_pass++;
            next_cycle();
        end
        for (int e = 1; e <= DONE_CYCLES + 4; e++) begin
            bus.core_done = 1'($urandom); bus.core_result = RES_BITS'($urandom);
            bus.img_buffer_full = 1'($urandom); bus.bnn_start = 1'($urandom); bus.result_ack = 1'b0;
            @(negedge clk);
            n_checks++; if (bus.err_timeout !== 1'b1) $display("FAIL err held: got %b want 1 at %0d", bus.err_timeout, e); else n_pass++;
            n_checks++; if (bus.result_ready !== 1'b0) $display("FAIL err result_ready: got %b want 0", bus.result_ready); else n_pass++;
            n_checks++; if (bus.result_out !== exp_result) $display("FAIL err result_out: got %0d want %0d", bus.result_out, exp_result); else n_pass++;
            n_checks++; if (bus.img_consumed !== 1'b0) $display("FAIL err img_consumed: got %b want 0", bus.img_consumed); else n_pass++;
            check_perf("err");
            next_cycle();
        end
        quiet_inputs();
        bus.result_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.err_timeout !== 1'b1) $display("FAIL err ack cycle: got %b want 1", bus.err_timeout); else n_pass++;
        next_cycle();
        check_idle("timeout_exit");
    endtask

    task automatic test_gating();
        quiet_inputs();
        bus.img_buffer_full = 1'b1; bus.img_in = rand_img();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++; if (bus.img_consumed !== 1'b0 || bus.core_start !== 1'b0) $display("FAIL gating full_only: got consumed=%b start=%b want 0 0", bus.img_consumed, bus.core_start); else n_pass++;
            next_cycle();
        end
        bus.img_buffer_full = 1'b0; bus.bnn_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (bus.img_consumed !== 1'b0 || bus.busy !== 1'b0) $display("FAIL gating start_only: got consumed=%b busy=%b want 0 0", bus.img_consumed, bus.busy); else n_pass++;
            next_cycle();
        end
        check_idle("gating_end");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_txn(rand_img(), RES_BITS'($urandom), $urandom_range(1, TIMEOUT_CYCLES),
                    $urandom_range(1, DONE_CYCLES + 3));
            if ($urandom_range(0, 1) == 1) check_idle("random_gap");
        end
        check_idle("random_end");
    endtask

    task automatic test_reset_mid_wait();
        launch(rand_img());
        next_cycle();
        next_cycle();
        rst = 1'b1; bus.img_buffer_full = 1'b1; bus.bnn_start = 1'b1;
        next_cycle();
        rst = 1'b0; quiet_inputs();
        exp_result = '0; exp_latency = '0;
        for (int k = 0; k < 4; k++) begin
            bus.core_done = 1'b1; bus.core_result = RES_BITS'($urandom);
            @(negedge clk);
            n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_wait busy: got %b want 0", bus.busy); else n_pass++;
            n_checks++; if (bus.result_ready !== 1'b0) $display("FAIL rst_wait result_ready: got %b want 0", bus.result_ready); else n_pass++;
            n_checks++; if (bus.result_out !== '0) $display("FAIL rst_wait result_out: got %0d want 0", bus.result_out); else n_pass++;
            n_checks++; if (bus.core_img !== '0) $display("FAIL rst_wait core_img: got %h want 0", bus.core_img); else n_pass++;
            check_perf("rst_wait");
            next_cycle();
        end
        // Reset landing on the LAUNCH cycle must suppress core_start.
        quiet_inputs();
        bus.img_buffer_full = 1'b1; bus.bnn_start = 1'b1; bus.img_in = rand_img();
        next_cycle();
        rst = 1'b1; bus.img_buffer_full = 1'b0; bus.bnn_start = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.core_start !== 1'b0) $display("FAIL rst_launch core_start: got %b want 0", bus.core_start); else n_pass++;
        next_cycle();
        rst = 1'b0;
        check_idle("rst_launch_end");
        run_txn(rand_img(), RES_BITS'($urandom), 5, 2);
        check_idle("recovery_end");
    endtask

    initial begin
        rst = 1'b1;
        quiet_inputs();
        bus.img_in = '0; bus.core_result = '0;
        test_reset();
        test_nominal();
        test_hold_expiry();
        test_done_on_last();
        test_back_to_back();
        test_timeout();
        test_gating();
        test_random();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
